// File: rtl/exe_unit_seq.sv
// exe_unit_seq: handshaked execution unit with registered result/flags, iterative CRC and multiply.
// Latency: operands latch on the accept edge; single-cycle ops are valid 1 edge later, CRC M+C+1, MUL M+1.
// Backpressure: o_ready only in IDLE; the result is held in DONE until i_ready; no queuing.
// Ports: i_clk/i_rst clock and async active-high reset; i_valid/o_ready request handshake with
//        i_oper, i_argA, i_argB, i_chain (A taken from the accumulator); o_valid/i_ready result
//        handshake with o_result, o_SF/o_OF/o_NF/o_BF flags and o_illegal.
module exe_unit_seq #(
    parameter int N     = 4,
    parameter int M     = 9,
    parameter int WPOLY = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_oper,
    input  logic [M-1:0] i_argA,
    input  logic [M-1:0] i_argB,
    input  logic         i_chain,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [M-1:0] o_result,
    output logic         o_SF,
    output logic         o_OF,
    output logic         o_NF,
    output logic         o_BF,
    output logic         o_illegal
);
    localparam int C  = WPOLY - 1;
    localparam int MC = M + C;
    localparam int CW = $clog2(MC + 1);
    localparam int IW = $clog2(M);
    localparam int ZW = $clog2(2 * M + 1);
    localparam int PW = $clog2(M + 1);

    localparam logic [CW-1:0] MUL_LAST  = CW'(M - 1);
    localparam logic [CW-1:0] CRC_LAST  = CW'(MC - 1);
    localparam logic [M-1:0]  M_AS_DATA = M'(M);

    localparam logic [N-1:0] OP_SUB  = N'(0);
    localparam logic [N-1:0] OP_XOR  = N'(1);
    localparam logic [N-1:0] OP_NAND = N'(2);
    localparam logic [N-1:0] OP_SHL  = N'(3);
    localparam logic [N-1:0] OP_SHR  = N'(4);
    localparam logic [N-1:0] OP_CRC  = N'(5);
    localparam logic [N-1:0] OP_CHK  = N'(6);
    localparam logic [N-1:0] OP_OH   = N'(7);
    localparam logic [N-1:0] OP_ZC   = N'(8);
    localparam logic [N-1:0] OP_U2SM = N'(9);
    localparam logic [N-1:0] OP_SMU2 = N'(10);
    localparam logic [N-1:0] OP_PRI  = N'(11);
    localparam logic [N-1:0] OP_MUL  = N'(12);
    localparam logic [N-1:0] OP_ILL  = N'(13);

    // LOAD is the cycle between accepting operands and producing/starting the result.
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_BUSY, S_DONE} state_t;

    state_t          r_state, w_state_next;
    logic [N-1:0]    r_oper;
    logic [M-1:0]    r_a, r_b, r_pp, r_acc, r_result;
    logic [MC-1:0]   r_msg;
    logic [C-1:0]    r_rem;
    logic [CW-1:0]   r_cnt;
    logic            r_sf, r_of, r_nf, r_bf, r_illegal;

    logic [M-1:0]    w_single, w_res, w_pp_next, w_neg_a, w_neg_sm;
    logic [C-1:0]    w_rem_shift, w_rem_next;
    logic [IW-1:0]   w_idx_or, w_pri;
    logic [ZW-1:0]   w_zeros;
    logic [PW-1:0]   w_pop;
    logic            w_is_mul, w_is_crc, w_last, w_load;

    assign o_ready   = (r_state == S_IDLE);
    assign o_valid   = (r_state == S_DONE);
    assign o_result  = r_result;
    assign o_SF      = r_sf;
    assign o_OF      = r_of;
    assign o_NF      = r_nf;
    assign o_BF      = r_bf;
    assign o_illegal = r_illegal;

    assign w_is_mul  = (r_oper == OP_MUL);
    assign w_is_crc  = (r_oper == OP_CRC) || (r_oper == OP_CHK);
    assign w_last    = (r_cnt == (w_is_mul ? MUL_LAST : CRC_LAST));

    // One serial CRC step: shift the next augmented message bit in, reduce on feedback.
    assign w_rem_shift = {r_rem[C-2:0], r_msg[MC-1]};
    assign w_rem_next  = r_rem[C-1] ? (w_rem_shift ^ r_b[C-1:0]) : w_rem_shift;
    // r_a is the shifted multiplicand, r_b[0] the current multiplier bit.
    assign w_pp_next   = r_b[0] ? (r_pp + r_a) : r_pp;

    assign w_neg_a  = '0 - r_a;
    assign w_neg_sm = '0 - {1'b0, r_a[M-2:0]};

    always_comb begin
        w_idx_or = '0;
        w_pri    = '0;
        w_zeros  = '0;
        for (int i = 0; i < M; i++) begin
            if (r_a[i]) begin
                w_idx_or = w_idx_or | IW'(i);
                w_pri    = IW'(i);
            end
            w_zeros = w_zeros + ZW'(!r_a[i]) + ZW'(!r_b[i]);
        end
    end

    always_comb begin
        w_single = '0;
        case (r_oper)
            OP_SUB:  w_single = r_a - r_b;
            OP_XOR:  w_single = r_a ^ r_b;
            OP_NAND: w_single = ~(r_a & r_b);
            OP_SHL:  w_single = (r_b >= M_AS_DATA) ? '0 : (r_a << r_b);
            OP_SHR:  w_single = (r_b >= M_AS_DATA) ? '0 : (r_a >> r_b);
            OP_OH:   w_single = M'(w_idx_or);
            OP_ZC:   w_single = M'(w_zeros);
            OP_U2SM: w_single = r_a[M-1] ? {1'b1, w_neg_a[M-2:0]} : r_a;
            OP_SMU2: w_single = r_a[M-1] ? w_neg_sm : r_a;
            OP_PRI:  w_single = M'(w_pri);
            default: w_single = '0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_res        = w_single;
        case (r_state)
            S_IDLE: if (i_valid) w_state_next = S_LOAD;
            S_LOAD: begin
                if (w_is_mul || w_is_crc) begin
                    w_state_next = S_BUSY;
                end else begin
                    w_state_next = S_DONE;
                    w_load       = 1'b1;
                end
            end
            S_BUSY: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                    w_load       = 1'b1;
                    w_res        = w_is_mul ? w_pp_next : M'(w_rem_next);
                end
            end
            S_DONE: if (i_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < M; i++) w_pop = w_pop + PW'(w_res[i]);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_oper <= '0; r_a <= '0; r_b <= '0; r_pp <= '0; r_acc <= '0;
            r_msg <= '0; r_rem <= '0; r_cnt <= '0; r_result <= '0;
            r_sf <= 1'b0; r_of <= 1'b0; r_nf <= 1'b0; r_bf <= 1'b0; r_illegal <= 1'b0;
        end else begin
            if (r_state == S_IDLE && i_valid) begin
                r_oper <= i_oper;
                r_a    <= i_chain ? r_acc : i_argA;
                r_b    <= i_argB;
            end
            if (r_state == S_LOAD) begin
                r_cnt <= '0;
                r_pp  <= '0;
                r_rem <= '0;
                r_msg <= (r_oper == OP_CHK) ? {r_a, r_b[M-1:M-C]} : {r_a, {C{1'b0}}};
            end
            if (r_state == S_BUSY) begin
                r_cnt <= r_cnt + CW'(1);
                if (w_is_mul) begin
                    r_pp <= w_pp_next;
                    r_a  <= r_a << 1;
                    r_b  <= r_b >> 1;
                end else begin
                    r_rem <= w_rem_next;
                    r_msg <= r_msg << 1;
                end
            end
            if (w_load) begin
                r_result  <= w_res;
                r_sf      <= w_res[M-1];
                r_of      <= &w_res;
                r_nf      <= ~w_pop[0];
                r_bf      <= (w_pop == PW'(1));
                r_illegal <= (r_oper >= OP_ILL);
            end
            if (r_state == S_DONE && i_ready) r_acc <= r_result;
        end
    end
endmodule

// File: tb/tb_exe_unit_seq.sv
module tb_exe_unit_seq;
    localparam int N = 4, M = 9, WPOLY = 4;

    logic         clk = 1'b0;
    logic         i_rst, i_valid, i_chain, i_ready;
    logic [N-1:0] i_oper;
    logic [M-1:0] i_argA, i_argB;
    logic         o_ready, o_valid, o_SF, o_OF, o_NF, o_BF, o_illegal;
    logic [M-1:0] o_result;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    exe_unit_seq #(.N(N), .M(M), .WPOLY(WPOLY)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_oper(i_oper), .i_argA(i_argA), .i_argB(i_argB), .i_chain(i_chain),
        .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
        .o_SF(o_SF), .o_OF(o_OF), .o_NF(o_NF), .o_BF(o_BF), .o_illegal(o_illegal)
    );

    typedef struct {
        logic [3:0] oper;
        logic [8:0] a;
        logic [8:0] b;
        logic       chain;
        logic [8:0] res;
        logic [3:0] fl;   // {SF, OF, NF, BF}
        logic       ill;
        int         lat;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [3:0] op, input logic [8:0] a, input logic [8:0] b,
                       input logic ch, input logic [8:0] res, input logic [3:0] fl,
                       input logic ill, input int lat);
        vecs.push_back('{op, a, b, ch, res, fl, ill, lat});
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge after the result was taken.
    task automatic do_op(input logic [3:0] op, input logic [8:0] a, input logic [8:0] b,
                         input logic ch, output logic [8:0] res, output logic [3:0] fl,
                         output logic ill, output int lat);
        int w;
        w = 0;
        while (!o_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        i_oper = op; i_argA = a; i_argB = b; i_chain = ch; i_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0; i_chain = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (o_valid) begin
                lat = n;
                break;
            end
        end
        res = o_result;
        fl  = {o_SF, o_OF, o_NF, o_BF};
        ill = o_illegal;
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] r;
        logic [3:0] f;
        logic       il;
        int         lt;
        logic [8:0] held;

        //   op     A       B       ch  result  SONB     ill lat
        add(4'd0,  9'h003, 9'h005, 0, 9'h1FE, 4'b1010, 0, 1);
        add(4'd1,  9'h0F0, 9'h0FF, 0, 9'h00F, 4'b0010, 0, 1);
        add(4'd2,  9'h1FF, 9'h000, 0, 9'h1FF, 4'b1100, 0, 1);
        add(4'd3,  9'h003, 9'd4,   0, 9'h030, 4'b0010, 0, 1);
        add(4'd3,  9'h003, 9'd9,   0, 9'h000, 4'b0010, 0, 1);
        add(4'd4,  9'h100, 9'd8,   0, 9'h001, 4'b0001, 0, 1);
        add(4'd4,  9'h1FF, 9'd200, 0, 9'h000, 4'b0010, 0, 1);
        add(4'd7,  9'h102, 9'h000, 0, 9'h009, 4'b0010, 0, 1);
        add(4'd8,  9'h1FF, 9'h000, 0, 9'h009, 4'b0010, 0, 1);
        add(4'd8,  9'h000, 9'h000, 0, 9'h012, 4'b0010, 0, 1);
        add(4'd9,  9'h1FE, 9'h000, 0, 9'h102, 4'b1010, 0, 1);
        add(4'd9,  9'h100, 9'h000, 0, 9'h100, 4'b1001, 0, 1);
        add(4'd9,  9'h005, 9'h000, 0, 9'h005, 4'b0010, 0, 1);
        add(4'd10, 9'h102, 9'h000, 0, 9'h1FE, 4'b1010, 0, 1);
        add(4'd10, 9'h100, 9'h000, 0, 9'h000, 4'b0010, 0, 1);
        add(4'd11, 9'h0A0, 9'h000, 0, 9'h007, 4'b0000, 0, 1);
        add(4'd11, 9'h000, 9'h000, 0, 9'h000, 4'b0010, 0, 1);
        add(4'd5,  9'h00D, 9'h00B, 0, 9'h001, 4'b0001, 0, 13);
        add(4'd6,  9'h00D, 9'h04B, 0, 9'h000, 4'b0010, 0, 13);
        add(4'd6,  9'h00D, 9'h0CB, 0, 9'h002, 4'b0001, 0, 13);
        add(4'd12, 9'h014, 9'h01E, 0, 9'h058, 4'b0000, 0, 10);
        add(4'd1,  9'h1AB, 9'h058, 1, 9'h000, 4'b0010, 0, 1);
        add(4'd12, 9'h1FF, 9'h1FF, 0, 9'h001, 4'b0001, 0, 10);
        add(4'd13, 9'h0AA, 9'h055, 0, 9'h000, 4'b0010, 1, 1);
        add(4'd15, 9'h1FF, 9'h1FF, 0, 9'h000, 4'b0010, 1, 1);

        i_rst = 1'b1; i_valid = 1'b0; i_chain = 1'b0; i_ready = 1'b0;
        i_oper = '0; i_argA = '0; i_argB = '0;
        repeat (3) @(negedge clk);
        chk("reset o_ready", o_ready, 1);
        chk("reset o_valid", o_valid, 0);
        chk("reset o_result", o_result, 0);
        chk("reset flags", {o_SF, o_OF, o_NF, o_BF, o_illegal}, 0);
        i_rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            do_op(vecs[i].oper, vecs[i].a, vecs[i].b, vecs[i].chain, r, f, il, lt);
            chk($sformatf("v%0d op%0d latency", i, vecs[i].oper), lt, vecs[i].lat);
            chk($sformatf("v%0d op%0d result", i, vecs[i].oper), r, vecs[i].res);
            chk($sformatf("v%0d op%0d flags", i, vecs[i].oper), f, vecs[i].fl);
            chk($sformatf("v%0d op%0d illegal", i, vecs[i].oper), il, vecs[i].ill);
        end

        // Result held while the consumer stalls; requests in DONE are ignored.
        i_oper = 4'd14; i_argA = 9'h0AA; i_argB = 9'h055; i_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        for (int n = 0; n < 10 && !o_valid; n++) @(negedge clk);
        chk("hold initial o_valid", o_valid, 1);
        held = o_result;
        i_oper = 4'd0; i_argA = 9'h003; i_argB = 9'h001; i_valid = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk($sformatf("hold c%0d o_valid", n), o_valid, 1);
            chk($sformatf("hold c%0d o_ready", n), o_ready, 0);
            chk($sformatf("hold c%0d result", n), o_result, 9'h000);
            chk($sformatf("hold c%0d ill/NF", n), {o_illegal, o_NF}, 2'b11);
        end
        i_valid = 1'b0; i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        chk("after take o_ready", o_ready, 1);
        chk("after take o_valid", o_valid, 0);
        @(negedge clk);
        chk("no queued op o_valid", o_valid, 0);
        chk("no queued op o_ready", o_ready, 1);

        // Reset in the middle of a multiply clears the accumulator.
        do_op(4'd0, 9'h003, 9'h005, 0, r, f, il, lt);
        chk("pre-reset result", r, 9'h1FE);
        i_oper = 4'd12; i_argA = 9'd20; i_argB = 9'd30; i_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid-mul o_ready", o_ready, 0);
        i_rst = 1'b1;
        #1;
        chk("async reset o_valid", o_valid, 0);
        chk("async reset o_ready", o_ready, 1);
        chk("async reset o_result", o_result, 0);
        @(negedge clk);
        i_rst = 1'b0;
        @(negedge clk);
        do_op(4'd1, 9'h1AB, 9'h055, 1, r, f, il, lt);
        chk("chain after reset latency", lt, 1);
        chk("chain after reset result", r, 9'h055);
        chk("chain after reset flags", f, 4'b0010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
